// File: rtl/onehot_decoder_seq_if.sv
// Decoder control/result bundle: the master drives the index controls and the slave returns the decode.
interface onehot_decoder_seq_if #(
   parameter int unsigned N    = 2,
   parameter int unsigned OUTS = 4
);
   logic            en;
   logic            mode;
   logic            load;
   logic [N-1:0]    addr;
   logic [OUTS-1:0] y;
   logic            valid;
   logic            oor;
   logic            wrap;

   // Controller side
   modport master (
      output en, mode, load, addr,
      input  y, valid, oor, wrap
   );

   // Decoder side
   modport slave (
      input  en, mode, load, addr,
      output y, valid, oor, wrap
   );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered N-to-OUTS one-hot decoder with enable, out-of-range flag and an
// internal scan counter that sweeps 0..OUTS-1 round-robin.
module onehot_decoder_seq #(
   parameter int unsigned N    = 2,
   parameter int unsigned OUTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   onehot_decoder_seq_if.slave  bus
);

   localparam int unsigned CW     = $clog2(OUTS);
   localparam logic [N:0]  OUTS_W = (N+1)'(OUTS);
   localparam logic [N-1:0] LAST  = N'(OUTS - 1);
   localparam logic [CW-1:0] CLAST = CW'(OUTS - 1);

   // Reject illegal output counts at elaboration
   generate
      if (OUTS < 2 || OUTS > (2 ** N)) begin : g_bad_outs
         $error("onehot_decoder_seq: OUTS must satisfy 2 <= OUTS <= 2**N");
      end
   endgenerate

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_n;
   logic [CW-1:0]   load_base;
   logic [N-1:0]    idx;
   logic            idx_ok;
   logic            addr_ok;
   logic            scan_step;
   logic [OUTS-1:0] y_n;
   logic            valid_n;
   logic            oor_n;
   logic            wrap_n;

   // Next-index increment modulo OUTS; never produces OUTS..2**CW-1
   function automatic logic [CW-1:0] inc_mod(input logic [CW-1:0] v);
      return (v == CLAST) ? '0 : v + CW'(1);
   endfunction

   // Index selection, decode and counter next-state
   always_comb begin
      idx       = bus.addr;
      idx_ok    = 1'b0;
      addr_ok   = 1'b0;
      scan_step = 1'b0;
      load_base = '0;
      cnt_n     = cnt;
      y_n       = '0;
      valid_n   = 1'b0;
      oor_n     = 1'b0;
      wrap_n    = 1'b0;

      // Scan mode follows the counter unless a load supplies the index directly
      if (bus.mode && !bus.load) begin
         idx = N'(cnt);
      end

      idx_ok    = ({1'b0, idx} < OUTS_W);
      addr_ok   = ({1'b0, bus.addr} < OUTS_W);
      scan_step = bus.en && bus.mode;

      if (bus.en) begin
         for (int unsigned i = 0; i < OUTS; i++) begin
            y_n[i] = (idx == N'(i));
         end
         valid_n = 1'b1;
         oor_n   = !idx_ok;
         wrap_n  = bus.mode && (idx == LAST);
      end

      // Loaded value is emitted this cycle when scanning, so advance past it
      if (bus.load) begin
         if (addr_ok) begin
            load_base = CW'(bus.addr);
         end else begin
            oor_n = 1'b1;
         end
         cnt_n = scan_step ? inc_mod(load_base) : load_base;
      end else if (scan_step) begin
         cnt_n = inc_mod(cnt);
      end
   end

   // Output and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bus.y     <= '0;
         bus.valid <= 1'b0;
         bus.oor   <= 1'b0;
         bus.wrap  <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         bus.y     <= y_n;
         bus.valid <= valid_n;
         bus.oor   <= oor_n;
         bus.wrap  <= wrap_n;
      end
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (OUTS=4 and OUTS=3, N=2) share
// one stimulus stream and are compared each cycle against an integer model.
module tb_onehot_decoder_seq;

   bit   clk = 1'b0;
   logic rst;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   onehot_decoder_seq_if #(.N(2), .OUTS(4)) if4 ();
   onehot_decoder_seq_if #(.N(2), .OUTS(3)) if3 ();

   onehot_decoder_seq #(.N(2), .OUTS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   onehot_decoder_seq #(.N(2), .OUTS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

   // Model state, index 0 = OUTS 4, index 1 = OUTS 3
   int outs_m [2] = '{4, 3};
   int cnt_m  [2] = '{0, 0};
   int ey     [2];
   int ev     [2];
   int eo     [2];
   int ew     [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural model of one decoder for one clock edge
   task automatic model(input int d, input bit r, input bit e, input bit m, input bit l, input int a);
      int outs;
      int idx;
      int base;
      outs = outs_m[d];
      if (r) begin
         ey[d] = 0; ev[d] = 0; eo[d] = 0; ew[d] = 0; cnt_m[d] = 0;
         return;
      end
      idx   = (m && !l) ? cnt_m[d] : a;
      ev[d] = e ? 1 : 0;
      ey[d] = (e && idx < outs) ? (1 << idx) : 0;
      eo[d] = ((e && idx >= outs) || (l && a >= outs)) ? 1 : 0;
      ew[d] = (e && m && idx == outs - 1) ? 1 : 0;
      if (l) begin
         base     = (a < outs) ? a : 0;
         cnt_m[d] = (e && m) ? (base + 1) % outs : base;
      end else if (e && m) begin
         cnt_m[d] = (cnt_m[d] + 1) % outs;
      end
   endtask

   task automatic check_all();
      chk("y4",     8'(if4.y),     8'(ey[0]));
      chk("valid4", 8'(if4.valid), 8'(ev[0]));
      chk("oor4",   8'(if4.oor),   8'(eo[0]));
      chk("wrap4",  8'(if4.wrap),  8'(ew[0]));
      chk("y3",     8'(if3.y),     8'(ey[1]));
      chk("valid3", 8'(if3.valid), 8'(ev[1]));
      chk("oor3",   8'(if3.oor),   8'(eo[1]));
      chk("wrap3",  8'(if3.wrap),  8'(ew[1]));
   endtask

   // Apply one cycle of inputs to both decoders and check after the edge
   task automatic step(input bit r, input bit e, input bit m, input bit l, input int a);
      rst      = r;
      if4.en   = e; if4.mode = m; if4.load = l; if4.addr = 2'(a);
      if3.en   = e; if3.mode = m; if3.load = l; if3.addr = 2'(a);
      @(posedge clk);
      model(0, r, e, m, l, a);
      model(1, r, e, m, l, a);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      if4.en = 1'b0; if4.mode = 1'b0; if4.load = 1'b0; if4.addr = '0;
      if3.en = 1'b0; if3.mode = 1'b0; if3.load = 1'b0; if3.addr = '0;

      // Reset for two cycles
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 3);
      chk("rst_y", 8'(if4.y), 8'h00);

      // Direct sweep 0..3
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0, k);
         chk("dir_y", 8'(if4.y), 8'(1 << k));
      end

      // Free-running scan, 9 cycles
      for (int k = 0; k < 9; k++) begin
         step(0, 1, 1, 0, 0);
         chk("scan_wrap", 8'(if4.wrap), 8'((k % 4) == 3));
      end

      // Load 2 with en, pause two cycles, resume
      step(0, 1, 1, 1, 2);
      chk("load_y", 8'(if4.y), 8'h04);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("pause_valid", 8'(if4.valid), 8'h00);
      step(0, 1, 1, 0, 0);
      chk("resume_y", 8'(if4.y), 8'h08);
      chk("resume_wrap", 8'(if4.wrap), 8'h01);
      step(0, 1, 1, 0, 0);
      chk("resume_next", 8'(if4.y), 8'h01);

      // Out of range on the OUTS=3 decoder
      step(0, 1, 0, 0, 3);
      chk("oor_dir", 8'(if3.oor), 8'h01);
      chk("oor_dir_y", 8'(if3.y), 8'h00);
      step(0, 0, 1, 1, 3);
      chk("oor_load", 8'(if3.oor), 8'h01);
      step(0, 1, 1, 0, 0);
      chk("oor_after", 8'(if3.y), 8'h01);

      // Mode switch mid-sweep (OUTS=4 counter is now 0)
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("ms_scan", 8'(if4.y), 8'h02);
      step(0, 1, 0, 0, 3);
      chk("ms_dir", 8'(if4.y), 8'h08);
      step(0, 1, 1, 0, 0);
      chk("ms_back", 8'(if4.y), 8'h04);

      // Reset mid-sweep
      step(1, 1, 1, 0, 0);
      chk("mid_rst", 8'(if4.valid), 8'h00);
      step(0, 1, 1, 0, 0);
      chk("post_rst", 8'(if4.y), 8'h01);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Parametrised, registered N-to-OUTS one-hot decoder with enable, out-of-range detection and an auto-scan mode. It generalises the team's 2-to-4 combinational decoder with a clocked output stage and an internal address counter. It serves as the select and strobe generator for mux/demux banks, and as a round-robin channel sweeper.

## Interface
- N, default 2: address width in bits.
- OUTS, default 4: number of decoded outputs. The legal range is 2 ≤ OUTS ≤ 2**N. Any other value is a compile-time error.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  decode enable; when high, the output register updates with a decoded index.
- mode  in  1  0 = direct (decode addr), 1 = scan (decode internal counter).
- load  in  1  loads the scan counter from addr; honoured in both modes.
- addr  in  N  binary index input.
- y  out  OUTS  registered one-hot output; bit i high means index i is selected.
- valid  out  1  registered; high when y holds a decode from the previous cycle's en.
- oor  out  1  registered one-cycle pulse; the index used was ≥ OUTS.
- wrap  out  1  registered; high in the cycle y[OUTS-1] is shown in scan mode.

## Operation
- Internal state: cnt, ceil(log2 OUTS) bits, holding the next scan index.
- Reset (rst=1 at an edge) sets y=0, valid=0, oor=0, wrap=0, cnt=0. Reset overrides all other inputs.
- The selected index idx is computed each cycle:
  - Scan mode with load=1: idx = addr.
  - Scan mode with load=0: idx = cnt.
  - Direct mode: idx = addr.
- When en=1:
  - If idx < OUTS: y ← onehot(idx), oor ← 0.
  - If idx ≥ OUTS: y ← 0, oor ← 1.
  - valid ← 1.
  - wrap ← 1 only if mode=1 and idx = OUTS-1; otherwise wrap ← 0.
- When en=0: y ← 0, valid ← 0, wrap ← 0, and oor ← 0 unless load raises it (see the counter rules below).
- Counter update, in priority order:
  1. load=1: cnt ← addr, or cnt ← 0 with oor ← 1 when addr ≥ OUTS. If additionally en=1 and mode=1, cnt ← (loaded value + 1) mod OUTS, because the loaded index is emitted this cycle.
  2. en=1 and mode=1 and load=0: cnt ← (cnt + 1) mod OUTS. The wrap is from OUTS-1 to 0; values OUTS..2**N-1 are never produced.
  3. Otherwise cnt holds.
- Switching mode mid-sweep retains cnt. Direct-mode decodes never disturb cnt.
- At most one bit of y is high at any time. y = 0 whenever valid = 0 or oor = 1.
- Behaviour for X/Z inputs is unspecified. The bench drives only 0/1.

## Timing
- Latency is 1 cycle from inputs sampled at edge k to y/valid/oor/wrap after edge k. There is no combinational path from input to output.
- Scan throughput is one index per enabled cycle. A full sweep takes OUTS consecutive en cycles.
- Deasserting en for a cycle pauses the sweep. On resume, the index that follows the last one shown is emitted.
- load and en together in scan mode: the loaded index appears after the same edge, with no bubble.
- Asserting rst mid-sweep clears the outputs at that edge. The next en in scan mode emits index 0.

## Test plan
- Reset then direct sweep (N=2, OUTS=4): rst for 2 cycles, then en=1, mode=0, addr=0,1,2,3 on consecutive cycles. Required: y=0001, 0010, 0100, 1000 each one cycle later; valid=1; oor=0; wrap=0. All outputs are 0 during reset.
- Free-running scan (N=2, OUTS=4): mode=1, en=1 for 9 cycles. Required: y = 0001, 0010, 0100, 1000, 0001, …; wrap=1 exactly on each 1000 cycle.
- Load and pause: in scan, load=1 with addr=2 and en=1, then en=0 for 2 cycles, then en=1. Required: y = 0100, then 0000 and 0000 with valid=0, then 1000 with wrap=1, then 0001.
- Out of range (N=2, OUTS=3): direct addr=3 with en=1 gives y=000, oor=1, valid=1. Scan load addr=3 with en=0 gives oor=1, and the next enabled scan cycle gives y=001.
- Mode switch: scan to show 001 then 010 (OUTS=4), switch to direct addr=3 for 1 cycle, then back to scan. Required: y = 1000, then 0100; the sweep continues from cnt.
- Reset mid-sweep: scan until y=0100, assert rst at the next edge, release, scan. Required: all outputs 0 after the rst edge, then y=0001.
